// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV32I load/store front-end: funct3 encodings,
// FSM state type and the request legality check.
package load_store_unit_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'd0;
    localparam logic [2:0] FUNCT3_LH  = 3'd1;
    localparam logic [2:0] FUNCT3_LW  = 3'd2;
    localparam logic [2:0] FUNCT3_LBU = 3'd4;
    localparam logic [2:0] FUNCT3_LHU = 3'd5;
    localparam logic [2:0] FUNCT3_SB  = 3'd0;
    localparam logic [2:0] FUNCT3_SH  = 3'd1;
    localparam logic [2:0] FUNCT3_SW  = 3'd2;

    typedef enum logic [2:0] {
        LSU_IDLE  = 3'd0,
        LSU_READ  = 3'd1,
        LSU_DATA  = 3'd2,
        LSU_WRITE = 3'd3,
        LSU_RESP  = 3'd4
    } lsu_state_t;

    // Illegal funct3 or misalignment for the access size; range is checked by the caller.
    function automatic logic access_error(input logic we, input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic err;
        err = 1'b0;
        if (we) begin
            case (funct3)
                FUNCT3_SB: err = 1'b0;
                FUNCT3_SH: err = offset[0];
                FUNCT3_SW: err = |offset;
                default:   err = 1'b1;
            endcase
        end else begin
            case (funct3)
                FUNCT3_LB, FUNCT3_LBU: err = 1'b0;
                FUNCT3_LH, FUNCT3_LHU: err = offset[0];
                FUNCT3_LW:             err = |offset;
                default:               err = 1'b1;
            endcase
        end
        return err;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts/extends a loaded byte or half, and merges
// store data into the old memory word for sub-word stores.
module mem_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed lane and apply the load extension.
    always_comb begin
        case (offset)
            2'd0:    byte_s = old_word[7:0];
            2'd1:    byte_s = old_word[15:8];
            2'd2:    byte_s = old_word[23:16];
            2'd3:    byte_s = old_word[31:24];
            default: byte_s = 8'd0;
        endcase
        half_s = offset[1] ? old_word[31:16] : old_word[15:0];

        case (funct3)
            FUNCT3_LB:  load_data = {{24{byte_s[7]}}, byte_s};
            FUNCT3_LH:  load_data = {{16{half_s[15]}}, half_s};
            FUNCT3_LW:  load_data = old_word;
            FUNCT3_LBU: load_data = {24'd0, byte_s};
            FUNCT3_LHU: load_data = {16'd0, half_s};
            default:    load_data = 32'd0;
        endcase
    end

    // Replace the addressed byte/half of the old word with the store data.
    always_comb begin
        store_word = old_word;
        case (funct3)
            FUNCT3_SB: begin
                case (offset)
                    2'd0:    store_word = {old_word[31:8], wdata[7:0]};
                    2'd1:    store_word = {old_word[31:16], wdata[7:0], old_word[7:0]};
                    2'd2:    store_word = {old_word[31:24], wdata[7:0], old_word[15:0]};
                    2'd3:    store_word = {wdata[7:0], old_word[23:0]};
                    default: store_word = old_word;
                endcase
            end
            FUNCT3_SH: begin
                if (offset[1]) begin
                    store_word = {wdata[15:0], old_word[15:0]};
                end else begin
                    store_word = {old_word[31:16], wdata[15:0]};
                end
            end
            FUNCT3_SW: store_word = wdata;
            default:   store_word = old_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store front-end for a 1-cycle-latency word memory without byte
// enables: sub-word stores are done as read-modify-write.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [2:0]            REQ_FUNCT3,
    input  logic [31:0]           REQ_ADDR,
    input  logic [31:0]           REQ_WDATA,
    output logic                  RSP_VALID,
    output logic [31:0]           RSP_DATA,
    output logic                  RSP_ERR,
    output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
    output logic                  MEM_WRITE_ENABLE,
    output logic [31:0]           MEM_WRITE_DATA,
    input  logic [31:0]           MEM_READ_DATA
);

    lsu_state_t            state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            offset_q, offset_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  req_err_s;
    logic [31:0]           load_data_s;
    logic [31:0]           store_word_s;

    assign req_err_s = access_error(REQ_WE, REQ_FUNCT3, REQ_ADDR[1:0])
                     | (|REQ_ADDR[31:ADDR_WIDTH+2]);

    mem_lane_align u_align (
        .funct3     (funct3_q),
        .offset     (offset_q),
        .old_word   (MEM_READ_DATA),
        .wdata      (wdata_q),
        .load_data  (load_data_s),
        .store_word (store_word_s)
    );

    // Next-state and datapath register updates for the request sequencer.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            LSU_IDLE: begin
                if (REQ_VALID) begin
                    we_d       = REQ_WE;
                    funct3_d   = REQ_FUNCT3;
                    offset_d   = REQ_ADDR[1:0];
                    wdata_d    = REQ_WDATA;
                    mem_addr_d = REQ_ADDR[ADDR_WIDTH+1:2];
                    if (req_err_s) begin
                        state_d     = LSU_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 32'd0;
                        rsp_err_d   = 1'b1;
                    end else if (REQ_WE && (REQ_FUNCT3 == FUNCT3_SW)) begin
                        // Full-word store needs no read of the old word.
                        state_d     = LSU_WRITE;
                        mem_wdata_d = REQ_WDATA;
                    end else begin
                        state_d = LSU_READ;
                    end
                end else begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_READ: state_d = LSU_DATA;
            LSU_DATA: begin
                if (we_q) begin
                    mem_wdata_d = store_word_s;
                    state_d     = LSU_WRITE;
                end else begin
                    rsp_data_d  = load_data_s;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = LSU_RESP;
                end
            end
            LSU_WRITE: begin
                rsp_data_d  = 32'd0;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = LSU_RESP;
            end
            LSU_RESP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= LSU_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            offset_q    <= 2'd0;
            wdata_q     <= 32'd0;
            mem_addr_q  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign REQ_READY        = (state_q == LSU_IDLE);
    assign MEM_WRITE_ENABLE = (state_q == LSU_WRITE);
    assign MEM_ADDRESS      = mem_addr_q;
    assign MEM_WRITE_DATA   = mem_wdata_q;
    assign RSP_VALID        = rsp_valid_q;
    assign RSP_DATA         = rsp_data_q;
    assign RSP_ERR          = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic checked against
// a byte-addressed reference memory, with a behavioural block_memory behind the unit.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic [9:0]  mem_address;
    logic        mem_we;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [0:1023];
    logic        mem_clr;
    logic [7:0]  ref_bytes [0:4095];

    int n_cmp = 0;
    int n_err = 0;
    int rsp_cnt = 0;
    int we_cnt = 0;
    int n_rsp_exp = 0;
    int n_we_exp = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(10)) dut (
        .CLK              (clk),
        .RSTN             (rst_n),
        .REQ_VALID        (req_valid),
        .REQ_READY        (req_ready),
        .REQ_WE           (req_we),
        .REQ_FUNCT3       (req_funct3),
        .REQ_ADDR         (req_addr),
        .REQ_WDATA        (req_wdata),
        .RSP_VALID        (rsp_valid),
        .RSP_DATA         (rsp_data),
        .RSP_ERR          (rsp_err),
        .MEM_ADDRESS      (mem_address),
        .MEM_WRITE_ENABLE (mem_we),
        .MEM_WRITE_DATA   (mem_wdata),
        .MEM_READ_DATA    (mem_rdata)
    );

    // Synchronous 1024x32 memory, one-cycle read latency, not reset by RSTN.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
        end else if (mem_we) begin
            mem[mem_address] <= mem_wdata;
        end
        mem_rdata <= mem[mem_address];
    end

    // Count response pulses and write cycles seen on the DUT pins.
    always @(negedge clk) begin
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (mem_we)    we_cnt  <= we_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory of 4096 bytes.
    function automatic void ref_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, output logic [31:0] d,
                                   output bit e, output int lat);
        int  size;
        bit  sgn;
        size = 0;
        sgn  = 1'b0;
        d    = 32'd0;
        if (we) begin
            if (f3 == 3'd0) size = 1;
            else if (f3 == 3'd1) size = 2;
            else if (f3 == 3'd2) size = 4;
        end else begin
            if (f3 == 3'd0 || f3 == 3'd4) size = 1;
            else if (f3 == 3'd1 || f3 == 3'd5) size = 2;
            else if (f3 == 3'd2) size = 4;
            sgn = (f3 < 3'd4);
        end
        e = (size == 0) || (a > 32'd4095) || ((int'(a[1:0]) % size) != 0);
        if (e) begin
            lat = 1;
            return;
        end
        if (we) begin
            for (int i = 0; i < size; i++) ref_bytes[a + i] = wd[8*i +: 8];
            lat = (size == 4) ? 2 : 4;
        end else begin
            for (int i = 0; i < size; i++) d[8*i +: 8] = ref_bytes[a + i];
            if (sgn && size < 4 && d[8*size-1]) d = d | (32'hFFFF_FFFF << (8*size));
            lat = 3;
        end
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    endfunction

    // Issue one request (called on a negedge) and check its response.
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold, output logic [31:0] got);
        logic [31:0] ed;
        bit          ee;
        int          el;
        int          lat;
        int          n;
        bit          busy_ok;
        ref_op(we, f3, a, wd, ed, ee, el);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            got = 32'd0;
            return;
        end
        @(posedge clk);
        lat = 1;
        busy_ok = 1'b1;
        @(negedge clk);
        while (!rsp_valid && lat < 12) begin
            if (req_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (req_ready) busy_ok = 1'b0;
        chk("rsp_seen", 32'(rsp_valid), 32'd1);
        chk("latency", 32'(lat), 32'(el));
        chk("rsp_data", rsp_data, ed);
        chk("rsp_err", 32'(rsp_err), 32'(ee));
        chk("ready_low_busy", 32'(busy_ok), 32'd1);
        n_rsp_exp++;
        if (we && !ee) n_we_exp++;
        got = rsp_data;
        if (!hold) req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int          we_snap;
        int          rsp_snap;
        logic [31:0] a;

        for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'd0;
        rst_n = 1'b0; mem_clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        @(negedge clk); @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_mem_addr", 32'(mem_address), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        mem_clr = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        // Word store/load, then sub-word stores and extended loads on the same word.
        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, d);
        do_req(1'b0, 3'd2, 32'h10, 32'd0, 1'b0, d);
        chk("t1_lw", d, 32'hDEADBEEF);
        do_req(1'b1, 3'd0, 32'h11, 32'h000000A5, 1'b0, d);
        chk("t2_word", mem[4], 32'hDEADA5EF);
        do_req(1'b0, 3'd0, 32'h11, 32'd0, 1'b0, d);
        chk("t2_lb", d, 32'hFFFFFFA5);
        do_req(1'b0, 3'd4, 32'h11, 32'd0, 1'b0, d);
        chk("t2_lbu", d, 32'h000000A5);
        do_req(1'b1, 3'd1, 32'h12, 32'h00001234, 1'b0, d);
        chk("t3_word", mem[4], 32'h1234A5EF);
        do_req(1'b0, 3'd1, 32'h12, 32'd0, 1'b0, d);
        chk("t3_lh", d, 32'h00001234);
        do_req(1'b0, 3'd5, 32'h10, 32'd0, 1'b0, d);
        chk("t3_lhu", d, 32'h0000A5EF);

        // Illegal requests: no memory write may happen.
        #1 we_snap = we_cnt;
        do_req(1'b0, 3'd2, 32'h13, 32'd0, 1'b0, d);
        do_req(1'b1, 3'd1, 32'h11, 32'hFFFF_FFFF, 1'b0, d);
        do_req(1'b0, 3'd3, 32'h10, 32'd0, 1'b0, d);
        do_req(1'b1, 3'd2, 32'h1000, 32'h12345678, 1'b0, d);
        @(negedge clk); #1;
        chk("t4_no_write", 32'(we_cnt), 32'(we_snap));
        chk("t4_word_kept", mem[4], 32'h1234A5EF);

        // Back-to-back with REQ_VALID held high, top word of memory.
        do_req(1'b1, 3'd2, 32'hFFC, 32'hCAFE0123, 1'b1, d);
        do_req(1'b0, 3'd2, 32'hFFC, 32'd0, 1'b1, d);
        chk("t5_lw_top", d, 32'hCAFE0123);
        do_req(1'b1, 3'd0, 32'hFFF, 32'h0000007E, 1'b1, d);
        do_req(1'b0, 3'd2, 32'hFFC, 32'd0, 1'b0, d);
        chk("t5_lw_top2", d, 32'h7EFE0123);

        // Reset while a byte store sits in its read phase.
        do_req(1'b1, 3'd2, 32'h20, 32'h11223344, 1'b0, d);
        @(negedge clk);
        #1 rsp_snap = rsp_cnt;
        req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h21; req_wdata = 32'h000000EE;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_rsp_data", rsp_data, 32'd0);
        chk("t6_mem_addr", 32'(mem_address), 32'd0);
        chk("t6_mem_we", 32'(mem_we), 32'd0);
        chk("t6_mem_wdata", mem_wdata, 32'd0);
        chk("t6_ready", 32'(req_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("t6_no_rsp", 32'(rsp_cnt), 32'(rsp_snap));
        chk("t6_word_kept", mem[8], 32'h11223344);
        @(negedge clk);

        // Random traffic against the reference memory.
        for (int k = 0; k < 160; k++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) a = $urandom() | 32'h0000_1000;
            else if (sel < 3) a = 32'hFC0 + $urandom_range(0, 63);
            else a = 32'h40 + $urandom_range(0, 63);
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(),
                   1'($urandom_range(0, 1)), d);
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int w = 16; w < 32; w++) chk($sformatf("word_%0d", w), mem[w], ref_word(w));
        for (int w = 1008; w < 1024; w++) chk($sformatf("word_%0d", w), mem[w], ref_word(w));
        chk("rsp_pulses", 32'(rsp_cnt), 32'(n_rsp_exp));
        chk("write_cycles", 32'(we_cnt), 32'(n_we_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
